// File: rtl/cubos_pkg.sv
// cubos_pkg: shared constants for the falling-cube state generator
package cubos_pkg;
    localparam int CUBE_COUNT = 5;
    localparam int X_BASE = 32;
    localparam int X_PITCH = 128;
    localparam int Y_RESET_STEP = 64;
    localparam logic [7:0] LFSR_SEED = 8'hA5;
    localparam logic [7:0] COLOR_RESERVADO = 8'hFF;
    localparam logic [7:0] COLOR_SUSTITUTO = 8'hE0;
    localparam logic [CUBE_COUNT-1:0][7:0] COLOR_RESET = {8'h1F, 8'hFC, 8'h03, 8'h1C, 8'hE0};

    function automatic logic [7:0] color_valido(input logic [7:0] v);
        return (v == COLOR_RESERVADO) ? COLOR_SUSTITUTO : v;
    endfunction
endpackage

// File: rtl/lfsr8.sv
// lfsr8: free-running 8-bit Fibonacci LFSR, taps x^8+x^6+x^5+x^4+1
module lfsr8
    import cubos_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    output logic [7:0] valor
);
    always_ff @(posedge clk or posedge reset)
        if (reset)
            valor <= LFSR_SEED;
        else
            valor <= {valor[6:0], valor[7] ^ valor[5] ^ valor[4] ^ valor[3]};
endmodule

// File: rtl/generador_estado_cubos.sv
// generador_estado_cubos: moves five falling cubes per frame and flags which cube covers the current pixel
module generador_estado_cubos
    import cubos_pkg::*;
#(
    parameter int CUBE_SIZE = 32,
    parameter int SPEED = 2,
    parameter int V_MAX = 480
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [9:0] pixel_x,
    input  logic [9:0] pixel_y,
    input  logic       frame_tick,
    input  logic       pausa,
    output logic [4:0] estado_cubos,
    output logic [7:0] color_cubo_1,
    output logic [7:0] color_cubo_2,
    output logic [7:0] color_cubo_3,
    output logic [7:0] color_cubo_4,
    output logic [7:0] color_cubo_5
);
    logic [7:0] lfsr_valor;
    logic [7:0] color_nuevo;
    logic [7:0] colores [CUBE_COUNT];
    logic [CUBE_COUNT-1:0] golpe;

    lfsr8 u_lfsr (
        .clk  (clk),
        .reset(reset),
        .valor(lfsr_valor)
    );

    assign color_nuevo = color_valido(lfsr_valor);

    for (genvar g = 0; g < CUBE_COUNT; g++) begin : g_cubo
        logic [9:0] y_q;
        logic [7:0] c_q;
        logic [10:0] y_sig, y_fin, x_ini, x_fin;
        // 11-bit sums keep the wrap test and the bottom edge exact near V_MAX
        assign y_sig = {1'b0, y_q} + 11'(SPEED * (g + 1));
        assign y_fin = {1'b0, y_q} + 11'(CUBE_SIZE);
        assign x_ini = 11'(X_BASE + X_PITCH * g);
        assign x_fin = x_ini + 11'(CUBE_SIZE);
        always_ff @(posedge clk or posedge reset)
            if (reset) begin
                y_q <= 10'(Y_RESET_STEP * g);
                c_q <= COLOR_RESET[g];
            end else if (frame_tick && !pausa) begin
                if (y_sig >= 11'(V_MAX)) begin
                    y_q <= '0;
                    c_q <= color_nuevo;
                end else begin
                    y_q <= y_sig[9:0];
                end
            end
        assign golpe[g] = ({1'b0, pixel_x} >= x_ini) && ({1'b0, pixel_x} < x_fin) &&
                          (pixel_y >= y_q) && ({1'b0, pixel_y} < y_fin);
        assign colores[g] = c_q;
    end

    always_ff @(posedge clk or posedge reset)
        if (reset)
            estado_cubos <= '0;
        else
            estado_cubos <= golpe;

    assign color_cubo_1 = colores[0];
    assign color_cubo_2 = colores[1];
    assign color_cubo_3 = colores[2];
    assign color_cubo_4 = colores[3];
    assign color_cubo_5 = colores[4];
endmodule

// File: doc/generador_estado_cubos.md
GENERADOR_ESTADO_CUBOS -- requirements
Module: generador_estado_cubos

Interface
REQ-001 SHALL have parameter CUBE_SIZE, default 32, cube edge in pixels.
REQ-002 SHALL have parameter SPEED, default 2, base fall step in pixels per frame.
REQ-003 SHALL have parameter V_MAX, default 480, visible lines; cube wraps at this y.
REQ-004 SHALL have port clk  input  1  single system clock, all logic rising-edge.
REQ-005 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-006 SHALL have port pixel_x  input  10  current VGA column.
REQ-007 SHALL have port pixel_y  input  10  current VGA line.
REQ-008 SHALL have port frame_tick  input  1  one-clk pulse per frame (end of visible area).
REQ-009 SHALL have port pausa  input  1  freezes cube motion while high.
REQ-010 SHALL have port estado_cubos  output  5  one-hot cube hit for current pixel, 0 = background.
REQ-011 SHALL have ports color_cubo_1..color_cubo_5  output  8 each  RGB332 colour of each cube.

Function
REQ-012 SHALL keep five cubes i=0..4 at fixed left edges X_i = 32 + 128*i, each with 10-bit top edge y_i.
REQ-013 SHALL advance y_i by SPEED*(i+1) on each frame_tick when pausa=0; no motion otherwise.
REQ-014 SHALL wrap when the new y_i >= V_MAX: y_i becomes 0 (no residual carry) in that same update.
REQ-015 SHALL load color_cubo_(i+1) from the LFSR value on the cycle cube i wraps.
REQ-016 SHALL substitute 8'hE0 when the LFSR value is 8'hFF (white is reserved for background).
REQ-017 SHALL use an 8-bit Fibonacci LFSR, taps x^8+x^6+x^5+x^4+1, seed 8'hA5, stepping every clk.
REQ-018 SHALL give all cubes wrapping on the same tick the same LFSR value.
REQ-019 SHALL set estado_cubos bit i when X_i <= pixel_x < X_i+CUBE_SIZE and y_i <= pixel_y < y_i+CUBE_SIZE.
REQ-020 SHALL register estado_cubos: one clk latency from pixel_x/pixel_y.
REQ-021 SHALL guarantee estado_cubos is 0 or one-hot (disjoint columns).
REQ-022 SHALL compute y_i+CUBE_SIZE at 11 bits so cubes near V_MAX compare without overflow.
REQ-023 SHALL ignore frame_tick while reset is high.
REQ-024 SHALL change y_i and colours only on frame_tick cycles (stable during frame drawing).

Reset
REQ-025 SHALL on reset set y_i = 64*i (0,64,128,192,256).
REQ-026 SHALL on reset set colours 1..5 to 8'hE0, 8'h1C, 8'h03, 8'hFC, 8'h1F.
REQ-027 SHALL on reset set estado_cubos = 0 and LFSR = 8'hA5.
REQ-028 SHALL on reset mid-frame take effect immediately; first motion on next frame_tick after release.

Structure
REQ-029 SHALL place CUBE_COUNT=5, X_BASE=32, X_PITCH=128, reset colours and LFSR seed in shared package cubos_pkg.
REQ-030 SHALL implement the LFSR as sub-module lfsr8 (clk, reset, 8-bit value out).
REQ-031 SHALL fit in 120-400 lines of RTL; cube update logic generated per cube.

Verification
REQ-032 Reset, pixel (40,70) -> estado_cubos=5'b00010 one clk later? No: cube1 at x160; pixel (40,10) -> 5'b00001; (170,70) -> 5'b00010.
REQ-033 One frame_tick, pausa=0 -> y = 2,68,134,200,266; pixel (544,265) -> 0, (544,266) -> 5'b10000.
REQ-034 frame_tick with pausa=1 -> all y_i unchanged, colours unchanged.
REQ-035 Cube4 at y=470, tick -> y_4=0 and color_cubo_5 = LFSR value that cycle (8'hE0 if 8'hFF).
REQ-036 Pixel (10,10) or (200,300) with no cube -> estado_cubos=0; never more than one bit set over full-frame sweep.
REQ-037 Assert reset during frame with y_i nonzero -> outputs return to REQ-025..027 values within the same cycle.
